cnn_stream_sink: RTL and testbench
==================================

Name: cnn_stream_sink

Overview:
- Receiving end of the cnn_top output stream (out_data/out_valid/downstream_stall).
- Buffers result words in a FIFO and drives the stall back to cnn_top.
- Exposes the words to the HPS/host through a small Avalon-MM slave: data pop, status, drop count, control.
- Instantiated beside cnn_top in the DE1-SoC top level; used as the output checker in system benches.

Parameters:
- DATA_WIDTH, 32, width of stream words and readdata.
- DEPTH, 16, FIFO entries; power of two, ≥4.
- SKID, 2, free entries reserved for words already in flight when stall rises; 1 ≤ SKID < DEPTH.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_data  in  DATA_WIDTH  stream word from cnn_top out_data.
- in_valid  in  1  word present this cycle (cnn_top out_valid).
- stall_out  out  1  to cnn_top downstream_stall; registered.
- avs_address  in  2  register select.
- avs_read  in  1  read strobe, single cycle.
- avs_write  in  1  write strobe, single cycle.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  registered read data.
- avs_readdatavalid  out  1  pulses one cycle after each avs_read.

Behaviour:
- Reset values: FIFO empty, count=0, flags=0, drop_count=0, avs_readdata=0, avs_readdatavalid=0, stall_out=1. stall_out falls on the first clock edge after reset deasserts.
- Push: in_valid=1 and (count<DEPTH or a pop occurs the same cycle) → word written at tail. Every valid word is accepted regardless of stall_out; the producer may overrun by up to SKID words.
- Drop: in_valid=1, count==DEPTH, no same-cycle pop → word discarded, overflow flag set (sticky), drop_count+1, saturating at 0xFFFF.
- stall_out: registered each cycle as (count_next ≥ DEPTH−SKID), where count_next is the post-update count. With DEPTH=16 and SKID=2 it asserts the cycle after count reaches 14.
- Host reads: latency 1. avs_readdata and avs_readdatavalid update on the edge after avs_read=1; avs_readdata holds its value otherwise.
- Address 0, DATA: returns the head word and pops it.
  - If empty: returns 0, no pop, underflow flag set (sticky).
  - Push and pop in the same cycle: count unchanged.
- Address 1, STATUS (no side effects): [15:0] count zero-extended; [16] empty; [17] full; [18] stall_out; [30] underflow; [31] overflow.
  - Reports the count before any same-cycle push or pop.
- Address 2: [15:0] drop_count, upper bits 0.
- Address 3: CONTROL. Reads return 0.
  - Write bit0=1 clears overflow, underflow and drop_count.
  - Write bit1=1 flushes the FIFO (count=0, pointers reset).
  - Flush wins over a same-cycle push or pop. The incoming word is discarded and not counted as a drop.
- Writes to addresses 0–2 are ignored. avs_read and avs_write in the same cycle: both take effect; a flush takes precedence over the pop.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- Reset mid-operation: all state cleared immediately (asynchronous); a pending readdatavalid is lost.

Test Plan:
- Reset held 5 cycles, then released → stall_out=1 during reset, 0 one cycle later; STATUS read returns 0x00010000 (empty).
- Push 0x11,0x22,0x33 on consecutive cycles, then 3 DATA reads → readdata 0x11,0x22,0x33, each with readdatavalid one cycle after its read; STATUS then 0x00010000.
- Stream 20 words 0..19 with in_valid held high, no reads → stall_out rises after the 14th word; words 0..15 stored; STATUS[31]=1, drop_count=4. The next 16 DATA reads return 0..15.
- FIFO full (16 words), push 0xAA and DATA read in the same cycle → readdata=head, count stays 16, no drop, overflow stays 0.
- DATA read when empty → readdata 0, STATUS[30]=1. Write CONTROL=1 → STATUS[30]=0, drop_count=0.
- 5 words stored, write CONTROL=2 while in_valid=1 with 0xBB → count=0, 0xBB not stored, drop_count unchanged, stall_out=0.

Source files
------------

// File: rtl/cnn_stream_sink.sv
// Stream sink for the cnn_top output: buffers words in a FIFO, back-pressures
// the producer early enough to absorb in-flight words, and serves an Avalon-MM host.
module cnn_stream_sink #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int SKID       = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  stall_out,
   input  logic [1:0]            avs_address,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [31:0]           avs_writedata,
   output logic [31:0]           avs_readdata,
   output logic                  avs_readdatavalid
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SKID);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic [15:0]           drop_q, drop_d;
   logic                  stall_q, stall_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;

   logic rd_data, wr_ctrl, clr, flush, empty, full, pop, push, drop;
   logic unused_wd;

   assign unused_wd = ^avs_writedata[31:2];

   always_comb begin
      rd_data = avs_read && (avs_address == 2'd0);
      wr_ctrl = avs_write && (avs_address == 2'd3);
      clr     = wr_ctrl && avs_writedata[0];
      flush   = wr_ctrl && avs_writedata[1];
      empty   = (count_q == '0);
      full    = (count_q == FULL_CNT);
      pop     = rd_data && !empty;
      // a same-cycle pop frees the slot, so a full FIFO still accepts the word
      push    = in_valid && !flush && (!full || pop);
      drop    = in_valid && !flush && full && !pop;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end

      // clear applies first so an event in the same cycle is still recorded
      ovf_d  = clr ? 1'b0 : ovf_q;
      udf_d  = clr ? 1'b0 : udf_q;
      drop_d = clr ? 16'h0 : drop_q;
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_d != 16'hFFFF) drop_d = drop_d + 16'h1;
      end
      if (rd_data && empty) udf_d = 1'b1;

      stall_d  = (count_d >= STALL_CNT);

      rvalid_d = avs_read;
      rdata_d  = rdata_q;
      if (avs_read) begin
         case (avs_address)
            2'd0:    rdata_d = empty ? 32'h0 : 32'(mem_q[rd_ptr_q]);
            2'd1:    rdata_d = {ovf_q, udf_q, 11'h0, stall_q, full, empty, 16'(count_q)};
            2'd2:    rdata_d = {16'h0, drop_q};
            default: rdata_d = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         drop_q   <= 16'h0;
         stall_q  <= 1'b1;
         rdata_q  <= 32'h0;
         rvalid_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         drop_q   <= drop_d;
         stall_q  <= stall_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign stall_out         = stall_q;
   assign avs_readdata      = rdata_q;
   assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_cnn_stream_sink.sv
// Scoreboard bench for cnn_stream_sink: a queue-based reference model predicts
// every read response and the stall level; a monitor compares them to the DUT.
module tb_cnn_stream_sink;
   localparam int DEPTH = 16;
   localparam int SKID  = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        stall_out;
   logic [1:0]  avs_address = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;

   cnn_stream_sink #(.DATA_WIDTH(32), .DEPTH(DEPTH), .SKID(SKID)) dut (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .stall_out(stall_out), .avs_address(avs_address), .avs_read(avs_read),
      .avs_write(avs_write), .avs_writedata(avs_writedata),
      .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid));

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] words[$];
   logic [31:0] exp_q[$];
   bit          m_ovf, m_udf;
   int          m_drop;
   bit          exp_stall;
   bit          chk_en = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      words.delete();
      exp_q.delete();
      m_ovf = 0; m_udf = 0; m_drop = 0;
      exp_stall = 1;
   endtask

   // one bus cycle: called at a negedge, returns at the next negedge
   task automatic cyc(input bit v, input logic [31:0] d, input bit rd, input logic [1:0] a,
                      input bit wr, input logic [31:0] wd);
      logic [31:0] rv;
      bit clr, flush, nxt_stall;
      in_valid = v; in_data = d; avs_read = rd; avs_address = a;
      avs_write = wr; avs_writedata = wd;
      clr   = wr && a == 2'd3 && wd[0];
      flush = wr && a == 2'd3 && wd[1];
      if (rd) begin
         case (a)
            2'd0: rv = (words.size() > 0) ? words[0] : 32'h0;
            2'd1: rv = {m_ovf, m_udf, 11'h0, exp_stall, words.size() == DEPTH,
                        words.size() == 0, 16'(words.size())};
            2'd2: rv = {16'h0, 16'(m_drop)};
            default: rv = 32'h0;
         endcase
         exp_q.push_back(rv);
      end
      if (clr) begin m_ovf = 0; m_udf = 0; m_drop = 0; end
      if (rd && a == 2'd0) begin
         if (words.size() > 0) void'(words.pop_front());
         else m_udf = 1;
      end
      if (v && !flush) begin
         if (words.size() < DEPTH) words.push_back(d);
         else begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
         end
      end
      if (flush) words.delete();
      nxt_stall = (words.size() >= DEPTH - SKID);
      @(posedge clock);
      #1 exp_stall = nxt_stall;
      @(negedge clock);
      in_valid = 0; avs_read = 0; avs_write = 0;
   endtask

   task automatic idle();            cyc(0, 0, 0, 0, 0, 0);  endtask
   task automatic push(input logic [31:0] d); cyc(1, d, 0, 0, 0, 0); endtask
   task automatic rd(input logic [1:0] a);    cyc(0, 0, 1, a, 0, 0); endtask
   task automatic ctrl(input logic [31:0] wd); cyc(0, 0, 0, 3, 1, wd); endtask

   // monitor: well clear of both clock edges
   always @(posedge clock) begin
      #3;
      if (chk_en) begin
         check("stall_out", {31'h0, stall_out}, {31'h0, exp_stall});
         if (avs_readdatavalid) begin
            if (exp_q.size() == 0) check("unexpected_rvalid", 32'h1, 32'h0);
            else check("readdata", avs_readdata, exp_q.pop_front());
         end else if (exp_q.size() > 0) begin
            check("missing_rvalid", 32'h0, 32'h1);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      model_reset();
      repeat (5) begin
         @(negedge clock);
         check("reset_stall", {31'h0, stall_out}, 32'h1);
         check("reset_rvalid", {31'h0, avs_readdatavalid}, 32'h0);
         check("reset_rdata", avs_readdata, 32'h0);
      end
      reset = 0;
      chk_en = 1;
      idle();
      rd(1);
      idle();
      check("status_after_reset_tb", avs_readdata, 32'h0001_0000);

      // three words through and back out
      push(32'h11); push(32'h22); push(32'h33);
      rd(0); rd(0); rd(0); rd(1);
      idle();

      // overrun: 20 words, 4 dropped
      for (int i = 0; i < 20; i++) push(i);
      rd(1); rd(2);
      for (int i = 0; i < 16; i++) rd(0);
      rd(1);
      ctrl(32'h1);

      // full FIFO with simultaneous push and pop
      for (int i = 0; i < 16; i++) push(32'h100 + i);
      cyc(1, 32'hAA, 1, 0, 0, 0);
      rd(1); rd(2);
      for (int i = 0; i < 17; i++) rd(0);   // last one underflows
      rd(1);
      ctrl(32'h1);
      rd(1); rd(2);

      // flush beats the incoming word
      for (int i = 0; i < 5; i++) push(32'h200 + i);
      cyc(1, 32'hBB, 0, 3, 1, 32'h2);
      rd(1); rd(2); rd(0);
      idle();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         bit v, r, w;
         logic [1:0] a;
         logic [31:0] wd;
         v  = ($urandom_range(0, 99) < ((i / 150) % 2 ? 80 : 35));
         r  = ($urandom_range(0, 99) < 40);
         w  = ($urandom_range(0, 99) < 4);
         a  = 2'($urandom_range(0, 3));
         wd = (a == 2'd3 && $urandom_range(0, 3) != 0) ? 32'(1 << $urandom_range(0, 1)) : $urandom;
         if (w && !r && $urandom_range(0, 1) == 1) a = 2'd3;
         cyc(v, $urandom, r, a, w, wd);
      end
      repeat (2) idle();

      // asynchronous reset with a read in flight
      for (int i = 0; i < 6; i++) push(32'h300 + i);
      @(posedge clock);
      @(negedge clock);
      avs_read = 1; avs_address = 2'd1;
      chk_en = 0;
      reset = 1;
      #1;
      check("midreset_stall", {31'h0, stall_out}, 32'h1);
      check("midreset_rvalid", {31'h0, avs_readdatavalid}, 32'h0);
      @(posedge clock);
      #1 check("midreset_lost_rvalid", {31'h0, avs_readdatavalid}, 32'h0);
      @(negedge clock);
      avs_read = 0;
      reset = 0;
      model_reset();
      chk_en = 1;
      idle();
      rd(1); rd(0);
      repeat (2) idle();

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
